lfsr_gen: RTL and testbench

Parametrised linear-feedback shift register: the next generation of the team's fixed 3-bit LFSR. Width, tap polynomial, reset seed and feedback topology (Fibonacci or Galois) are parameters. Adds step enable, runtime seed load, all-zero lock-up recovery and on-line period measurement. Used as a pseudo-random source and as a self-checking sequence generator in benches and datapaths.

---
 rtl/lfsr_pkg.sv | 51 +++++
 rtl/lfsr_next.sv | 32 +++
 rtl/lfsr_gen.sv | 129 ++++++++++++
 tb/tb_lfsr_gen.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/lfsr_pkg.sv
// Shared definitions for the parametrised LFSR: feedback topology selectors,
// the per-edge action decode, known-maximal tap masks and the Galois mask helper.
package lfsr_pkg;

   // Widest register the generator supports; helpers work at this width.
   localparam int unsigned MAX_WIDTH = 16;

   // Feedback topology selectors for the MODE parameter.
   localparam bit MODE_FIB = 1'b0;
   localparam bit MODE_GAL = 1'b1;

   // What the register does on a given clock edge, in priority order.
   typedef enum logic [1:0] {
      ACT_HOLD    = 2'd0,  // neither load nor en: everything held
      ACT_LOAD    = 2'd1,  // runtime seed load, wins over en
      ACT_RECOVER = 2'd2,  // en while stuck at all-zero: reseed
      ACT_STEP    = 2'd3   // normal advance by one step
   } lfsr_action_e;

   // Fibonacci tap masks giving a maximal-length sequence (period 2^w-1).
   // Bit i set means Q[i] feeds the XOR. Unsupported widths return 0.
   function automatic logic [MAX_WIDTH-1:0] default_taps(input int unsigned width);
      logic [MAX_WIDTH-1:0] taps;
      case (width)
         3:       taps = 16'h0006;
         4:       taps = 16'h000C;
         5:       taps = 16'h0014;
         6:       taps = 16'h0030;
         7:       taps = 16'h0060;
         8:       taps = 16'h00B8;
         9:       taps = 16'h0110;
         10:      taps = 16'h0240;
         11:      taps = 16'h0500;
         12:      taps = 16'h0829;
         13:      taps = 16'h100D;
         14:      taps = 16'h2015;
         15:      taps = 16'h6000;
         16:      taps = 16'hD008;
         default: taps = '0;
      endcase
      return taps;
   endfunction

   // Galois XOR mask derived from a Fibonacci-style tap mask: the taps move up
   // one place and bit 0 always receives the bit shifted out of the top.
   // Callers keep only the low WIDTH bits of the result.
   function automatic logic [MAX_WIDTH-1:0] galois_mask(input logic [MAX_WIDTH-1:0] taps);
      return (taps << 1) | MAX_WIDTH'(1);
   endfunction

endpackage

// File: rtl/lfsr_next.sv
// Combinational next-state of the LFSR for either feedback topology.
// Holds no state; the owning block decides when the result is taken.
module lfsr_next
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH = 3,
   parameter logic [WIDTH-1:0] TAPS  = 3'b110,
   parameter bit               MODE  = MODE_FIB
) (
   input  logic [WIDTH-1:0] q_i,
   output logic [WIDTH-1:0] next_o
);

   // Galois mask resolved at elaboration; only the low WIDTH bits are relevant.
   localparam logic [MAX_WIDTH-1:0] GAL_FULL = galois_mask(MAX_WIDTH'(TAPS));
   localparam logic [WIDTH-1:0]     GAL_MASK = GAL_FULL[WIDTH-1:0];

   generate
      if (MODE == MODE_GAL) begin : g_galois
         // Shift left; when the outgoing top bit is 1, fold it back through the mask.
         always_comb begin
            next_o = {q_i[WIDTH-2:0], 1'b0} ^ (q_i[WIDTH-1] ? GAL_MASK : '0);
         end
      end else begin : g_fibonacci
         // Shift left and insert the parity of the tapped bits at the bottom.
         always_comb begin
            next_o = {q_i[WIDTH-2:0], ^(q_i & TAPS)};
         end
      end
   endgenerate

endmodule

// File: rtl/lfsr_gen.sv
// Parametrised LFSR with step enable, runtime seed load, all-zero lock-up
// recovery and on-line measurement of the sequence period against a
// reference value (the last seed applied).
module lfsr_gen
   import lfsr_pkg::*;
#(
   parameter int unsigned      WIDTH = 3,
   parameter logic [WIDTH-1:0] TAPS  = 3'b110,
   parameter logic [WIDTH-1:0] SEED  = 3'b001,
   parameter bit               MODE  = MODE_FIB
) (
   input  logic             clk,
   input  logic             set,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] seed_in,
   output logic [WIDTH-1:0] Q,
   output logic             serial_out,
   output logic             wrap,
   output logic             lockup,
   output logic [WIDTH-1:0] step_cnt,
   output logic [WIDTH-1:0] period,
   output logic             period_valid
);

   // Architectural state.
   logic [WIDTH-1:0] q_q,      q_d;
   logic [WIDTH-1:0] ref_q,    ref_d;
   logic [WIDTH-1:0] cnt_q,    cnt_d;
   logic [WIDTH-1:0] period_q, period_d;
   logic             pvalid_q, pvalid_d;
   logic             wrap_q,   wrap_d;
   logic             lockup_q, lockup_d;

   // Helpers.
   logic [WIDTH-1:0] next_q;
   logic [WIDTH-1:0] cnt_inc;
   lfsr_action_e     action;

   lfsr_next #(
      .WIDTH (WIDTH),
      .TAPS  (TAPS),
      .MODE  (MODE)
   ) u_next (
      .q_i    (q_q),
      .next_o (next_q)
   );

   // Step counter increment, pinned at all-ones for tap sets that never return.
   assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + WIDTH'(1);

   // Decode what this edge does: load beats en, and en on all-zero reseeds.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned and infers a latch.
      action = ACT_HOLD;
      if (load) begin
         action = ACT_LOAD;
      end else if (en) begin
         action = (q_q == '0) ? ACT_RECOVER : ACT_STEP;
      end
   end

   // Next-state for the register, reference, counters and one-cycle pulses.
   always_comb begin
      q_d      = q_q;
      ref_d    = ref_q;
      cnt_d    = cnt_q;
      period_d = period_q;
      pvalid_d = pvalid_q;
      wrap_d   = 1'b0;
      lockup_d = 1'b0;
      case (action)
         ACT_LOAD: begin
            q_d   = seed_in;
            ref_d = seed_in;
            cnt_d = '0;
         end
         ACT_RECOVER: begin
            q_d      = SEED;
            ref_d    = SEED;
            cnt_d    = '0;
            lockup_d = 1'b1;
         end
         ACT_STEP: begin
            q_d = next_q;
            if (next_q == ref_q) begin
               wrap_d   = 1'b1;
               period_d = cnt_inc;
               pvalid_d = 1'b1;
               cnt_d    = '0;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: ;
      endcase
   end

   // State registers; set restores the seed and discards any measured period.
   always_ff @(posedge clk or posedge set) begin
      if (set) begin
         q_q      <= SEED;
         ref_q    <= SEED;
         cnt_q    <= '0;
         period_q <= '0;
         pvalid_q <= 1'b0;
         wrap_q   <= 1'b0;
         lockup_q <= 1'b0;
      end else begin
         // NOTE: registers use non-blocking assignment so every flop samples pre-edge values.
         q_q      <= q_d;
         ref_q    <= ref_d;
         cnt_q    <= cnt_d;
         period_q <= period_d;
         pvalid_q <= pvalid_d;
         wrap_q   <= wrap_d;
         lockup_q <= lockup_d;
      end
   end

   assign Q            = q_q;
   assign serial_out   = q_q[WIDTH-1];
   assign wrap         = wrap_q;
   assign lockup       = lockup_q;
   assign step_cnt     = cnt_q;
   assign period       = period_q;
   assign period_valid = pvalid_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: Fibonacci and Galois 3-bit instances share
// stimulus from a vector table; a 4-bit maximal instance checks a longer period.
module tb_lfsr_gen;
   import lfsr_pkg::*;

   logic       clk = 1'b0;
   logic       set;
   logic       en;
   logic       load;
   logic [2:0] seed_in;
   logic       en4;

   // Fibonacci DUT outputs
   logic [2:0] f_q, f_cnt, f_period;
   logic       f_ser, f_wrap, f_lock, f_pv;
   // Galois DUT outputs
   logic [2:0] g_q, g_cnt, g_period;
   logic       g_ser, g_wrap, g_lock, g_pv;
   // 4-bit Fibonacci DUT outputs
   logic [3:0] w_q, w_cnt, w_period;
   logic       w_ser, w_wrap, w_lock, w_pv;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   lfsr_gen #(.WIDTH(3), .TAPS(3'b110), .SEED(3'b001), .MODE(MODE_FIB)) u_fib (
      .clk(clk), .set(set), .en(en), .load(load), .seed_in(seed_in),
      .Q(f_q), .serial_out(f_ser), .wrap(f_wrap), .lockup(f_lock),
      .step_cnt(f_cnt), .period(f_period), .period_valid(f_pv));

   lfsr_gen #(.WIDTH(3), .TAPS(3'b110), .SEED(3'b001), .MODE(MODE_GAL)) u_gal (
      .clk(clk), .set(set), .en(en), .load(load), .seed_in(seed_in),
      .Q(g_q), .serial_out(g_ser), .wrap(g_wrap), .lockup(g_lock),
      .step_cnt(g_cnt), .period(g_period), .period_valid(g_pv));

   lfsr_gen #(.WIDTH(4), .TAPS(4'b1100), .SEED(4'b0001), .MODE(MODE_FIB)) u_w4 (
      .clk(clk), .set(set), .en(en4), .load(1'b0), .seed_in(4'b0000),
      .Q(w_q), .serial_out(w_ser), .wrap(w_wrap), .lockup(w_lock),
      .step_cnt(w_cnt), .period(w_period), .period_valid(w_pv));

   typedef struct {
      logic       load;
      logic       en;
      logic [2:0] seed;
      logic [2:0] q;
      logic       wrap;
      logic       lockup;
      logic [2:0] cnt;
      logic [2:0] period;
      logic       pvalid;
      logic       chk_gal;
      logic [2:0] gq;
   } vec_t;

   vec_t vecs[20];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   initial begin
      //        load  en   seed    q      wrap  lock  cnt    per    pv   gal  gq
      vecs[0]  = '{1'b0, 1'b1, 3'd0, 3'b010, 1'b0, 1'b0, 3'd1, 3'd0, 1'b0, 1'b1, 3'b010};
      vecs[1]  = '{1'b0, 1'b1, 3'd0, 3'b101, 1'b0, 1'b0, 3'd2, 3'd0, 1'b0, 1'b1, 3'b100};
      vecs[2]  = '{1'b0, 1'b1, 3'd0, 3'b011, 1'b0, 1'b0, 3'd3, 3'd0, 1'b0, 1'b1, 3'b101};
      vecs[3]  = '{1'b0, 1'b1, 3'd0, 3'b111, 1'b0, 1'b0, 3'd4, 3'd0, 1'b0, 1'b1, 3'b111};
      vecs[4]  = '{1'b0, 1'b1, 3'd0, 3'b110, 1'b0, 1'b0, 3'd5, 3'd0, 1'b0, 1'b1, 3'b011};
      vecs[5]  = '{1'b0, 1'b1, 3'd0, 3'b100, 1'b0, 1'b0, 3'd6, 3'd0, 1'b0, 1'b1, 3'b110};
      vecs[6]  = '{1'b0, 1'b1, 3'd0, 3'b001, 1'b1, 1'b0, 3'd0, 3'd7, 1'b1, 1'b1, 3'b001};
      // hold with en low
      vecs[7]  = '{1'b0, 1'b0, 3'd0, 3'b001, 1'b0, 1'b0, 3'd0, 3'd7, 1'b1, 1'b0, 3'b000};
      // load 101 together with en: load only
      vecs[8]  = '{1'b1, 1'b1, 3'd5, 3'b101, 1'b0, 1'b0, 3'd0, 3'd7, 1'b1, 1'b0, 3'b000};
      vecs[9]  = '{1'b0, 1'b1, 3'd0, 3'b011, 1'b0, 1'b0, 3'd1, 3'd7, 1'b1, 1'b0, 3'b000};
      vecs[10] = '{1'b0, 1'b1, 3'd0, 3'b111, 1'b0, 1'b0, 3'd2, 3'd7, 1'b1, 1'b0, 3'b000};
      vecs[11] = '{1'b0, 1'b1, 3'd0, 3'b110, 1'b0, 1'b0, 3'd3, 3'd7, 1'b1, 1'b0, 3'b000};
      vecs[12] = '{1'b0, 1'b1, 3'd0, 3'b100, 1'b0, 1'b0, 3'd4, 3'd7, 1'b1, 1'b0, 3'b000};
      vecs[13] = '{1'b0, 1'b1, 3'd0, 3'b001, 1'b0, 1'b0, 3'd5, 3'd7, 1'b1, 1'b0, 3'b000};
      vecs[14] = '{1'b0, 1'b1, 3'd0, 3'b010, 1'b0, 1'b0, 3'd6, 3'd7, 1'b1, 1'b0, 3'b000};
      vecs[15] = '{1'b0, 1'b1, 3'd0, 3'b101, 1'b1, 1'b0, 3'd0, 3'd7, 1'b1, 1'b0, 3'b000};
      // load zero, then en recovers from lock-up
      vecs[16] = '{1'b1, 1'b0, 3'd0, 3'b000, 1'b0, 1'b0, 3'd0, 3'd7, 1'b1, 1'b0, 3'b000};
      vecs[17] = '{1'b0, 1'b1, 3'd0, 3'b001, 1'b0, 1'b1, 3'd0, 3'd7, 1'b1, 1'b0, 3'b000};
      vecs[18] = '{1'b0, 1'b1, 3'd0, 3'b010, 1'b0, 1'b0, 3'd1, 3'd7, 1'b1, 1'b0, 3'b000};
      vecs[19] = '{1'b0, 1'b0, 3'd0, 3'b010, 1'b0, 1'b0, 3'd1, 3'd7, 1'b1, 1'b0, 3'b000};

      set = 1'b1; en = 1'b0; load = 1'b0; seed_in = 3'd0; en4 = 1'b0;
      #12;
      check("reset_q",        32'(f_q),      32'h1);
      check("reset_pvalid",   32'(f_pv),     32'h0);
      check("reset_period",   32'(f_period), 32'h0);
      check("reset_cnt",      32'(f_cnt),    32'h0);
      check("reset_wrap",     32'(f_wrap),   32'h0);
      check("reset_lockup",   32'(f_lock),   32'h0);
      check("reset_gal_q",    32'(g_q),      32'h1);
      check("reset_w4_q",     32'(w_q),      32'h1);
      @(negedge clk);
      set = 1'b0;

      for (int i = 0; i < 20; i++) begin
         load = vecs[i].load; en = vecs[i].en; seed_in = vecs[i].seed;
         @(posedge clk);
         #1;
         check($sformatf("v%0d_q", i),      32'(f_q),      32'(vecs[i].q));
         check($sformatf("v%0d_ser", i),    32'(f_ser),    32'(vecs[i].q[2]));
         check($sformatf("v%0d_wrap", i),   32'(f_wrap),   32'(vecs[i].wrap));
         check($sformatf("v%0d_lockup", i), 32'(f_lock),   32'(vecs[i].lockup));
         check($sformatf("v%0d_cnt", i),    32'(f_cnt),    32'(vecs[i].cnt));
         check($sformatf("v%0d_period", i), 32'(f_period), 32'(vecs[i].period));
         check($sformatf("v%0d_pvalid", i), 32'(f_pv),     32'(vecs[i].pvalid));
         if (vecs[i].chk_gal) begin
            check($sformatf("v%0d_gal_q", i),      32'(g_q),      32'(vecs[i].gq));
            check($sformatf("v%0d_gal_wrap", i),   32'(g_wrap),   32'(vecs[i].wrap));
            check($sformatf("v%0d_gal_period", i), 32'(g_period), 32'(vecs[i].period));
            check($sformatf("v%0d_gal_cnt", i),    32'(g_cnt),    32'(vecs[i].cnt));
         end
         @(negedge clk);
      end

      // Four steps from 010, then an asynchronous set between clock edges.
      load = 1'b0; en = 1'b1;
      begin
         logic [2:0] exp4 [4];
         exp4 = '{3'b101, 3'b011, 3'b111, 3'b110};
         for (int i = 0; i < 4; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("pre_set_q%0d", i), 32'(f_q), 32'(exp4[i]));
            @(negedge clk);
         end
      end
      en = 1'b0;
      #2;
      set = 1'b1;
      #1;
      check("async_set_q",      32'(f_q),      32'h1);
      check("async_set_cnt",    32'(f_cnt),    32'h0);
      check("async_set_pvalid", 32'(f_pv),     32'h0);
      check("async_set_period", 32'(f_period), 32'h0);
      @(negedge clk);
      set = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("post_set_hold_q%0d", i), 32'(f_q),  32'h1);
         check($sformatf("post_set_pv%0d", i),     32'(f_pv), 32'h0);
      end

      // 4-bit maximal polynomial: wrap only on the 15th step, period 15.
      @(negedge clk);
      en4 = 1'b1;
      for (int i = 0; i < 15; i++) begin
         @(posedge clk);
         #1;
         check($sformatf("w4_wrap%0d", i), 32'(w_wrap), (i == 14) ? 32'h1 : 32'h0);
      end
      check("w4_q",      32'(w_q),      32'h1);
      check("w4_period", 32'(w_period), 32'd15);
      check("w4_pvalid", 32'(w_pv),     32'h1);
      check("w4_cnt",    32'(w_cnt),    32'h0);
      @(negedge clk);
      en4 = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
